// File: rtl/round_sat_arbiter_if.sv
// Request/result bundle for round_sat_arbiter: per-lane requests in, one rounded result out.
interface round_sat_arbiter_if #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned para_int_bits  = 7,
   parameter int unsigned para_frac_bits = 9
);
   localparam int unsigned W   = para_int_bits + para_frac_bits;
   localparam int unsigned IW  = 2 * W;
   localparam int unsigned IDW = $clog2(NUM_REQ);
   localparam int unsigned CW  = 16;

   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ*IW-1:0] req_data;
   logic [NUM_REQ-1:0]    req_ready;
   logic                  out_valid;
   logic                  out_ready;
   logic [W-1:0]          out_data;
   logic [IDW-1:0]        out_id;
   logic                  sat_flag;
   logic [CW-1:0]         sat_count;
   logic                  clr_count;

   modport master (
      output req_valid, req_data, out_ready, clr_count,
      input  req_ready, out_valid, out_data, out_id, sat_flag, sat_count
   );

   modport slave (
      input  req_valid, req_data, out_ready, clr_count,
      output req_ready, out_valid, out_data, out_id, sat_flag, sat_count
   );
endinterface

// File: rtl/round_sat_arbiter.sv
// Round-robin arbitrated round-half-up stage with a single valid/ready output register.
// Saturation, sat_flag and sat_count are live only when ROUNDER_SAT_EN is defined.
module round_sat_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned para_int_bits  = 7,
   parameter int unsigned para_frac_bits = 9
) (
   input logic               clk,
   input logic               rst_n,
   round_sat_arbiter_if.slave bus
);
   localparam int unsigned W   = para_int_bits + para_frac_bits;
   localparam int unsigned IW  = 2 * W;
   localparam int unsigned IDW = $clog2(NUM_REQ);
   localparam int unsigned F   = para_frac_bits;
   localparam int unsigned RW  = IW - F + 1;
   localparam int unsigned CW  = 16;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [W-1:0]     out_data_q, out_data_d;
   logic [IDW-1:0]   out_id_q, out_id_d;
   logic             sat_flag_q, sat_flag_d;
   logic [CW-1:0]    sat_count_q, sat_count_d;

   logic [IDW-1:0]   winner_c;
   logic             found_c;
   logic             can_load_c;
   logic             xfer_c;
   logic [NUM_REQ-1:0] grant_c;
   logic [IW-1:0]    sel_c;
   logic [RW-1:0]    r_c;
   logic [W-1:0]     rnd_c;
   logic             sat_c;
   logic             unused_c;

   function automatic logic [IDW-1:0] lane_at(input logic [IDW-1:0] base,
                                              input int unsigned off);
      logic [IDW:0] pos;
      pos = {1'b0, base} + (IDW+1)'(off);
      if (pos >= (IDW+1)'(NUM_REQ)) pos = pos - (IDW+1)'(NUM_REQ);
      return pos[IDW-1:0];
   endfunction

   // First valid lane at or after the round-robin pointer
   always_comb begin
      winner_c = '0;
      found_c  = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!found_c && bus.req_valid[lane_at(ptr_q, i)]) begin
            found_c  = 1'b1;
            winner_c = lane_at(ptr_q, i);
         end
      end
   end

   assign can_load_c = (state_q == EMPTY) || bus.out_ready;
   assign xfer_c     = rst_n && found_c && can_load_c;

   always_comb begin
      grant_c = '0;
      if (xfer_c) grant_c[winner_c] = 1'b1;
   end

   assign bus.req_ready = grant_c;

   always_comb begin
      ptr_d = ptr_q;
      if (xfer_c) ptr_d = (winner_c == IDW'(NUM_REQ - 1)) ? '0 : winner_c + IDW'(1);
   end

   always_comb begin
      sel_c = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (winner_c == IDW'(k)) sel_c = bus.req_data[k*IW +: IW];
      end
   end

   // Round half up; one guard bit above the shifted word keeps the +1 from wrapping
   assign r_c = {sel_c[IW-1], sel_c[IW-1:F]} + RW'(sel_c[F-1]);

`ifdef ROUNDER_SAT_EN
   always_comb begin
      rnd_c = r_c[W-1:0];
      sat_c = 1'b0;
      if (!r_c[RW-1] && (|r_c[RW-1:W-1])) begin
         rnd_c = {1'b0, {(W-1){1'b1}}};
         sat_c = 1'b1;
      end else if (r_c[RW-1] && !(&r_c[RW-1:W-1])) begin
         rnd_c = {1'b1, {(W-1){1'b0}}};
         sat_c = 1'b1;
      end
   end
   assign unused_c = ^sel_c[F-2:0];
`else
   assign rnd_c    = r_c[W-1:0];
   assign sat_c    = 1'b0;
   assign unused_c = ^{sel_c[F-2:0], r_c[RW-1:W]};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (xfer_c) state_d = FULL;
         FULL:    if (bus.out_ready && !xfer_c) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   // Result register loads on every transfer; the saturation counter sticks at all-ones
   always_comb begin
      out_data_d  = out_data_q;
      out_id_d    = out_id_q;
      sat_flag_d  = sat_flag_q;
      sat_count_d = sat_count_q;
      if (xfer_c) begin
         out_data_d = rnd_c;
         out_id_d   = winner_c;
         sat_flag_d = sat_c;
      end
      if (bus.clr_count) begin
         sat_count_d = '0;
      end else if (xfer_c && sat_c && !(&sat_count_q)) begin
         sat_count_d = sat_count_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         out_data_q  <= '0;
         out_id_q    <= '0;
         sat_flag_q  <= 1'b0;
         sat_count_q <= '0;
      end else begin
         ptr_q       <= ptr_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
         sat_flag_q  <= sat_flag_d;
         sat_count_q <= sat_count_d;
      end
   end

   assign bus.out_valid = (state_q == FULL);
   assign bus.out_data  = out_data_q;
   assign bus.out_id    = out_id_q;
   assign bus.sat_flag  = sat_flag_q;
   assign bus.sat_count = sat_count_q;
endmodule
